// File: rtl/temporal_ngram_encoder_pkg.sv
// Shared types, default sizes and helpers for the temporal N-gram encoder.
package temporal_ngram_encoder_pkg;

    localparam int unsigned HV_DIMENSION_DEF = 32'd2048;
    localparam int unsigned NGRAM_MAX_DEF    = 32'd5;
    localparam int unsigned NSIZE_W_DEF      = $clog2(NGRAM_MAX_DEF + 32'd1);

    // FILL: history not yet deep enough for an N-gram; RUN: every accept emits one.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } ngram_state_e;

    // Map a requested N-gram size onto the legal range 1..max_n.
    function automatic int unsigned clamp_nsize(input int unsigned req, input int unsigned max_n);
        int unsigned res;
        if (req == 32'd0) begin
            res = 32'd1;
        end else if (req > max_n) begin
            res = max_n;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/temporal_ngram_encoder_ngram_history.sv
// Permuted history chain and masked XOR reduction forming the N-gram.
// Stage k holds rho^k of the input accepted k samples ago.
module ngram_history
    import temporal_ngram_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int unsigned NGRAM_MAX    = NGRAM_MAX_DEF,
    parameter int unsigned NSIZE_W      = $clog2(NGRAM_MAX + 32'd1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ShiftEn_SI,
    input  logic                    Clear_SI,
    input  logic [0:HV_DIMENSION-1] Hypervector_DI,
    input  logic [NSIZE_W-1:0]      NSize_SI,
    output logic [0:HV_DIMENSION-1] NGram_DO
);

    logic [0:HV_DIMENSION-1] hist_r [1:NGRAM_MAX-1];
    logic [0:HV_DIMENSION-1] ngram_s;

    // One-position cyclic permutation: the last bit wraps around to bit 0.
    function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] v);
        return {v[HV_DIMENSION-1], v[0:HV_DIMENSION-2]};
    endfunction

    // History chain: flush on reset/clear, otherwise shift-and-permute on accept.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI || Clear_SI) begin
            for (int unsigned k = 1; k < NGRAM_MAX; k++) begin
                hist_r[k] <= '0;
            end
        end else if (ShiftEn_SI) begin
            hist_r[1] <= rho(Hypervector_DI);
            for (int unsigned k = 2; k < NGRAM_MAX; k++) begin
                hist_r[k] <= rho(hist_r[k-1]);
            end
        end
    end

    // XOR of the current input with the N-1 most recent history stages.
    always_comb begin
        ngram_s = Hypervector_DI;
        for (int unsigned k = 1; k < NGRAM_MAX; k++) begin
            ngram_s = ngram_s ^ ((k < 32'(NSize_SI)) ? hist_r[k] : {HV_DIMENSION{1'b0}});
        end
    end

    assign NGram_DO = ngram_s;

endmodule

// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder: warm-up FSM, size latch, handshake and output register.
module temporal_ngram_encoder
    import temporal_ngram_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int unsigned NGRAM_MAX    = NGRAM_MAX_DEF,
    parameter int unsigned NSIZE_W      = $clog2(NGRAM_MAX + 32'd1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    input  logic                    LastIn_SI,
    input  logic [NSIZE_W-1:0]      NGramSize_SI,
    input  logic                    Clear_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output logic                    LastOut_SO
);

    ngram_state_e            state_r, state_s, init_state_s;
    logic [NSIZE_W-1:0]      nsize_r, nsize_req_s;
    logic [NSIZE_W-1:0]      fill_cnt_r, fill_cnt_s;
    logic                    ready_s, accept_s, hist_clear_s;
    logic                    valid_out_r, last_out_r;
    logic [0:HV_DIMENSION-1] hv_out_r;
    logic [0:HV_DIMENSION-1] ngram_s;

    assign nsize_req_s  = NSIZE_W'(clamp_nsize(32'(NGramSize_SI), NGRAM_MAX));
    assign init_state_s = (nsize_req_s == NSIZE_W'(1)) ? ST_RUN : ST_FILL;

    // The output slot is free when empty or being drained this cycle.
    assign ready_s  = !Reset_RI && !Clear_SI && (!valid_out_r || ReadyIn_SI);
    assign accept_s = ValidIn_SI && ready_s;

    // A Last accept ends the sequence, so the history restarts empty.
    assign hist_clear_s = Clear_SI || (accept_s && LastIn_SI);

    ngram_history #(
        .HV_DIMENSION (HV_DIMENSION),
        .NGRAM_MAX    (NGRAM_MAX),
        .NSIZE_W      (NSIZE_W)
    ) u_history (
        .Clk_CI         (Clk_CI),
        .Reset_RI       (Reset_RI),
        .ShiftEn_SI     (accept_s),
        .Clear_SI       (hist_clear_s),
        .Hypervector_DI (HypervectorIn_DI),
        .NSize_SI       (nsize_r),
        .NGram_DO       (ngram_s)
    );

    // Next state and fill count: clear restarts warm-up, FILL counts up to N-1.
    always_comb begin
        state_s    = state_r;
        fill_cnt_s = fill_cnt_r;
        if (Clear_SI) begin
            fill_cnt_s = '0;
            state_s    = init_state_s;
        end else if (accept_s) begin
            if (LastIn_SI) begin
                fill_cnt_s = '0;
                state_s    = (nsize_r == NSIZE_W'(1)) ? ST_RUN : ST_FILL;
            end else begin
                case (state_r)
                    ST_FILL: begin
                        fill_cnt_s = fill_cnt_r + NSIZE_W'(1);
                        state_s    = ((fill_cnt_r + NSIZE_W'(1)) == (nsize_r - NSIZE_W'(1))) ? ST_RUN : ST_FILL;
                    end
                    ST_RUN: begin
                        fill_cnt_s = fill_cnt_r;
                        state_s    = ST_RUN;
                    end
                    default: begin
                        fill_cnt_s = '0;
                        state_s    = ST_FILL;
                    end
                endcase
            end
        end else begin
            state_s    = state_r;
            fill_cnt_s = fill_cnt_r;
        end
    end

    // State, fill count and N-gram size registers; size latches only on reset/clear.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_r    <= init_state_s;
            fill_cnt_r <= '0;
            nsize_r    <= nsize_req_s;
        end else begin
            state_r    <= state_s;
            fill_cnt_r <= fill_cnt_s;
            if (Clear_SI) begin
                nsize_r <= nsize_req_s;
            end
        end
    end

    // Output register: load on a RUN accept, drop valid once taken, hold under backpressure.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            valid_out_r <= 1'b0;
            last_out_r  <= 1'b0;
            hv_out_r    <= '0;
        end else if (accept_s && (state_r == ST_RUN)) begin
            valid_out_r <= 1'b1;
            last_out_r  <= LastIn_SI;
            hv_out_r    <= ngram_s;
        end else if (valid_out_r && ReadyIn_SI) begin
            valid_out_r <= 1'b0;
        end
    end

    assign ReadyOut_SO       = ready_s;
    assign ValidOut_SO       = valid_out_r;
    assign LastOut_SO        = last_out_r;
    assign HypervectorOut_DO = hv_out_r;

endmodule
